decoder_fec: RTL and testbench
==============================

# decoder_fec

Receive-side FEC block: accepts 16-bit Hamming SECDED code words as produced by the transmit encoder, corrects any single-bit error, and flags double-bit errors. Returns 8-bit message data with per-word status. It is a 2-stage valid/ready pipeline placed between the demodulated-data path and the receive message buffer. It also keeps saturating error counters for link-quality monitoring.

## Interface
- DATA_WIDTH, 8, message width; `message_data_t`.
- HAMMING_WIDTH, 16, code word width; `encoded_message_data_t`.
- COUNT_WIDTH, 16, width of each error counter.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a code word.
- in_ready  out  1  decoder accepts in_data this cycle.
- in_data  in  16  code word.
- out_valid  out  1  out_* fields valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  decoded (corrected if possible) message.
- out_corrected  out  1  single error fixed in this word.
- out_uncorrectable  out  1  double or invalid-position error; out_data is raw extracted data.
- clear_counters  in  1  synchronous clear of both counters.
- corrected_count  out  COUNT_WIDTH  words with out_corrected, saturating.
- uncorrectable_count  out  COUNT_WIDTH  words with out_uncorrectable, saturating.

## Operation
- Code layout (positions 1..12 map to in_data[0..11]): parity at bits 0,1,3,7 (positions 1,2,4,8); data d0..d7 at bits 2,4,5,6,8,9,10,11. Bit 12 is the overall parity bit: XOR of bits [12:0] is 0. Bits [15:13] are padding and are ignored.
- Syndrome s[3:0] is the XOR of the positions of all set bits in [11:0]. Overall check p is the XOR of [12:0].
- s=0, p=0: clean. Data passes through; both flags 0.
- s in 1..12, p=1: single error. Flip the bit at position s, extract data, out_corrected=1.
- s=0, p=1: error in bit 12 only. Data is unaffected; out_corrected=1.
- s in 13..15, p=1: out_uncorrectable=1.
- s!=0, p=0: double error. out_uncorrectable=1.
- Stage 1 registers the accepted word plus s and p. Stage 2 registers the corrected data and flags.
- Counters increment by 1 on each output handshake (out_valid && out_ready) whose flag is set, and saturate at all-ones.
- If clear_counters coincides with an increment, clear wins and the counter becomes 0.

## Timing
- Reset: in_ready=1, out_valid=0, out_data=0, both flags 0, both counters 0; both stage valid bits cleared.
- Latency: a word accepted in cycle N appears on out_* in cycle N+2 when there is no backpressure.
- Throughput: 1 word per cycle.
- in_ready = !s1_valid || !s2_valid || out_ready. No combinational path from in_valid to in_ready.
- While out_valid && !out_ready, out_data and both flags are held stable.
- Stage 1 is held while stage 2 is stalled. With both stages full, at most 2 words are in flight.
- Reset asserted mid-stream drops all in-flight words immediately and clears the counters. Output resumes only for words accepted after rst_n rises.
- in_data is ignored when in_valid=0 or in_ready=0.

## Structure
- Add to `encoder_fec_pkg`:
  - `localparam CODE_BITS = 13`
  - `typedef logic[3:0] syndrome_t`
  - `typedef enum logic[1:0] {DEC_CLEAN, DEC_CORRECTED, DEC_UNCORRECTABLE} decode_status_t`
  - data-bit position constants shared with the encoder
- Sub-module `hamming_syndrome`: combinational; input 16-bit word, outputs `syndrome_t` and p. Used by stage 1.
- Top level `decoder_fec` contains both pipeline stages, the handshake logic and the counters.

## Test plan
- Clean word: 0x0F77 (data 0xFF) -> out_data=0xFF, flags 0, 2 cycles after acceptance; counters unchanged.
- Single data-bit error: 0x0020 (bit 5 set, data 0x00) -> out_data=0x00, out_corrected=1, corrected_count=1.
- Overall-parity error: 0x1F77 -> out_data=0xFF, out_corrected=1.
- Double error: 0x0003 -> out_uncorrectable=1, out_data=0x00, uncorrectable_count=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles while driving a stream of 1024 random encoded words.
  - Required response: in_ready drops after 2 accepted words, out_* stay stable, no word is lost or duplicated.
  - Check every output against a scoreboard queue.
- Saturation and reset:
  - Preload via 65535 double-error words plus 1 more -> uncorrectable_count stays 0xFFFF.
  - clear_counters together with an increment -> 0.
  - rst_n pulsed low mid-stream -> out_valid=0 immediately and counters 0.

Source files
------------

// File: rtl/encoder_fec_pkg.sv
// Shared types and code-word layout for the Hamming SECDED encoder/decoder pair.
// Code positions 1..12 live in bits 0..11, bit 12 is overall parity, bits 15:13 are padding.
package encoder_fec_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int HAMMING_WIDTH = 16;
    localparam int COUNT_WIDTH   = 16;
    localparam int CODE_BITS     = 13;

    typedef logic [DATA_WIDTH-1:0]    message_data_t;
    typedef logic [HAMMING_WIDTH-1:0] encoded_message_data_t;
    typedef logic [3:0]               syndrome_t;

    typedef enum logic [1:0] {
        DEC_CLEAN,
        DEC_CORRECTED,
        DEC_UNCORRECTABLE
    } decode_status_t;

    // Bit index of d0..d7 inside the code word (d0 is element 0).
    localparam logic [DATA_WIDTH-1:0][3:0] DATA_BIT_IDX = {
        4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2
    };

    function automatic message_data_t extract_data(input logic [CODE_BITS-1:0] code);
        message_data_t data;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data[i] = code[DATA_BIT_IDX[i]];
        end
        return data;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity check for one 16-bit code word.
module hamming_syndrome
    import encoder_fec_pkg::*;
(
    input  encoded_message_data_t word,
    output syndrome_t             syndrome,
    output logic                  parity
);

    logic unused_padding;
    assign unused_padding = ^word[HAMMING_WIDTH-1:CODE_BITS];

    // Syndrome is the XOR of the 1-based positions of every set bit in [11:0].
    always_comb begin
        syndrome = '0;
        for (int i = 0; i < CODE_BITS - 1; i++) begin
            if (word[i]) begin
                syndrome = syndrome ^ syndrome_t'(i + 1);
            end
        end
        parity = ^word[CODE_BITS-1:0];
    end

endmodule

// File: rtl/decoder_fec.sv
// Two-stage valid/ready SECDED decoder: stage 1 holds word + syndrome, stage 2 holds
// corrected data and status; saturating counters track corrected/uncorrectable words.
module decoder_fec
    import encoder_fec_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  encoded_message_data_t  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output message_data_t          out_data,
    output logic                   out_corrected,
    output logic                   out_uncorrectable,
    input  logic                   clear_counters,
    output logic [COUNT_WIDTH-1:0] corrected_count,
    output logic [COUNT_WIDTH-1:0] uncorrectable_count
);

    syndrome_t in_syndrome;
    logic      in_parity;

    hamming_syndrome u_syndrome (
        .word     (in_data),
        .syndrome (in_syndrome),
        .parity   (in_parity)
    );

    logic                 s1_valid;
    logic [CODE_BITS-1:0] s1_code;
    syndrome_t            s1_syndrome;
    logic                 s1_parity;

    logic                 s2_valid;
    message_data_t        s2_data;
    decode_status_t       s2_status;

    logic                 s1_load;
    logic                 s2_load;

    // A stage may load when it is empty or the stage after it is moving.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    logic [CODE_BITS-1:0] fixed_code;
    decode_status_t       s1_status;

    always_comb begin
        fixed_code = s1_code;
        s1_status  = DEC_CLEAN;
        if (s1_parity) begin
            if (s1_syndrome == '0) begin
                s1_status = DEC_CORRECTED;
            end else if (s1_syndrome <= syndrome_t'(CODE_BITS - 1)) begin
                s1_status  = DEC_CORRECTED;
                fixed_code = s1_code ^ (CODE_BITS'(1) << (s1_syndrome - 4'd1));
            end else begin
                s1_status = DEC_UNCORRECTABLE;
            end
        end else if (s1_syndrome != '0) begin
            s1_status = DEC_UNCORRECTABLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_code     <= '0;
            s1_syndrome <= '0;
            s1_parity   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code     <= in_data[CODE_BITS-1:0];
                s1_syndrome <= in_syndrome;
                s1_parity   <= in_parity;
            end
        end
    end

    // Uncorrectable words keep the raw extracted data since fixed_code is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_status <= DEC_CLEAN;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data   <= extract_data(fixed_code);
                s2_status <= s1_status;
            end
        end
    end

    assign out_valid         = s2_valid;
    assign out_data          = s2_data;
    assign out_corrected     = (s2_status == DEC_CORRECTED);
    assign out_uncorrectable = (s2_status == DEC_UNCORRECTABLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corrected_count     <= '0;
            uncorrectable_count <= '0;
        end else if (clear_counters) begin
            corrected_count     <= '0;
            uncorrectable_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_corrected && (corrected_count != '1)) begin
                corrected_count <= corrected_count + 1'b1;
            end
            if (out_uncorrectable && (uncorrectable_count != '1)) begin
                uncorrectable_count <= uncorrectable_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_fec.sv
// Self-checking bench for decoder_fec: nearest-codeword reference model, scoreboard queue,
// directed vectors, backpressure, random stream, counter saturation/clear and mid-stream reset.
module tb_decoder_fec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_corrected;
    logic        out_uncorrectable;
    logic        clear_counters = 1'b0;
    logic [15:0] corrected_count;
    logic [15:0] uncorrectable_count;

    always #5 clk = ~clk;

    decoder_fec dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_corrected       (out_corrected),
        .out_uncorrectable   (out_uncorrectable),
        .clear_counters      (clear_counters),
        .corrected_count     (corrected_count),
        .uncorrectable_count (uncorrectable_count)
    );

    int assert_count = 0;
    int fail_count   = 0;
    int cycle        = 0;
    int model_corr   = 0;
    int model_unc    = 0;

    // 1-based code positions of d0..d7.
    int dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef struct {
        logic [7:0] data;
        int         status;
        int         cycle;
    } exp_t;

    exp_t exp_q[$];

    logic       hold_active = 1'b0;
    logic [7:0] hold_data;
    logic       hold_c;
    logic       hold_u;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic logic [7:0] model_extract(input logic [12:0] code);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = code[dpos[i] - 1];
        return d;
    endfunction

    function automatic logic [12:0] model_encode(input logic [7:0] d);
        logic [12:0] cw;
        logic        par;
        cw = '0;
        for (int i = 0; i < 8; i++) cw[dpos[i] - 1] = d[i];
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++) begin
                if (((pos >> k) & 1) == 1 && cw[pos - 1]) par = ~par;
            end
            cw[(1 << k) - 1] = par;
        end
        cw[12] = ^cw[11:0];
        return cw;
    endfunction

    // Nearest-codeword decode: valid word is clean, one flip away is corrected, else uncorrectable.
    task automatic model_decode(input logic [15:0] w, output logic [7:0] data, output int status);
        logic [12:0] raw;
        logic [12:0] t;
        raw    = w[12:0];
        data   = model_extract(raw);
        status = 2;
        if (model_encode(model_extract(raw)) == raw) begin
            status = 0;
        end else begin
            for (int b = 0; b < 13; b++) begin
                t = raw ^ (13'd1 << b);
                if (status == 2 && model_encode(model_extract(t)) == t) begin
                    status = 1;
                    data   = model_extract(t);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_valid;
        cycle++;
        if (!rst_n) begin
            exp_q.delete();
            model_corr  = 0;
            model_unc   = 0;
            hold_active = 1'b0;
        end else begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].cycle <= cycle - 2);
            checkOutput("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            checkOutput("out_valid", out_valid, exp_valid);
            checkOutput("corrected_count", corrected_count, model_corr);
            checkOutput("uncorrectable_count", uncorrectable_count, model_unc);
            if (out_valid && hold_active) begin
                checkOutput("stall_data_stable", out_data, hold_data);
                checkOutput("stall_corr_stable", out_corrected, hold_c);
                checkOutput("stall_unc_stable", out_uncorrectable, hold_u);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("output_without_word", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_corrected", out_corrected, e.status == 1);
                    checkOutput("out_uncorrectable", out_uncorrectable, e.status == 2);
                    if (e.status == 1 && model_corr < 65535) model_corr++;
                    if (e.status == 2 && model_unc < 65535) model_unc++;
                end
            end
            if (clear_counters) begin
                model_corr = 0;
                model_unc  = 0;
            end
            hold_active = out_valid && !out_ready;
            hold_data   = out_data;
            hold_c      = out_corrected;
            hold_u      = out_uncorrectable;
            if (in_valid && in_ready) begin
                model_decode(in_data, e.data, e.status);
                e.cycle = cycle;
                exp_q.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic rdy,
                                 input logic clr, output logic acc);
        in_valid       = v;
        in_data        = d;
        out_ready      = rdy;
        clear_counters = clr;
        @(negedge clk);
        acc = v && in_ready && rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic directedWord(input logic [15:0] w, input logic [7:0] ed, input logic ec, input logic eu);
        logic acc;
        applyStimulus(1'b1, w, 1'b1, 1'b0, acc);
        checkOutput("directed_accept", acc, 1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, acc);
        checkOutput("directed_valid", out_valid, 1);
        checkOutput("directed_data", out_data, ed);
        checkOutput("directed_corr", out_corrected, ec);
        checkOutput("directed_unc", out_uncorrectable, eu);
    endtask

    task automatic drain(input int n);
        logic acc;
        repeat (n) applyStimulus(1'b0, 16'($urandom), 1'b1, 1'b0, acc);
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    task automatic midReset();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_corr_count", corrected_count, 0);
        checkOutput("reset_unc_count", uncorrectable_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] randomWord();
        logic [12:0] cw;
        int          k;
        int          a;
        int          b;
        cw = model_encode(8'($urandom));
        k  = $urandom_range(0, 9);
        a  = $urandom_range(0, 12);
        b  = (a + $urandom_range(1, 12)) % 13;
        if (k >= 4 && k < 7) cw = cw ^ (13'd1 << a);
        else if (k >= 7 && k < 9) cw = cw ^ (13'd1 << a) ^ (13'd1 << b);
        else if (k == 9) cw = 13'($urandom);
        return {3'($urandom), cw};
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  md;
        int          ms;
        logic        acc;
        int          accepted;
        int          idx;
        int          tries;
        logic [15:0] w;
        logic [15:0] bp_words [3];
        bp_words = '{16'h0F77, 16'h0020, 16'h1F77};

        $display("[TB] Pinning reference model");
        md = model_encode(8'hFF);
        checkOutput("model_encode_FF", md, 8'h77);
        checkOutput("model_encode_FF_full", {3'b000, model_encode(8'hFF)}, 16'h0F77);
        model_decode(16'h0020, md, ms);
        checkOutput("model_0020_status", ms, 1);
        model_decode(16'h1F77, md, ms);
        checkOutput("model_1F77_data", md, 8'hFF);
        model_decode(16'h0003, md, ms);
        checkOutput("model_0003_status", ms, 2);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_flags", {out_corrected, out_uncorrectable}, 0);
        checkOutput("reset_counts", {corrected_count, uncorrectable_count}, 0);
        rst_n = 1'b1;

        $display("[TB] Directed vectors");
        directedWord(16'h0F77, 8'hFF, 1'b0, 1'b0);
        directedWord(16'h0020, 8'h00, 1'b1, 1'b0);
        directedWord(16'h1F77, 8'hFF, 1'b1, 1'b0);
        directedWord(16'h0003, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, acc);
        checkOutput("directed_corr_count", corrected_count, 2);
        checkOutput("directed_unc_count", uncorrectable_count, 1);

        $display("[TB] Backpressure with three queued words");
        accepted = 0;
        idx      = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, bp_words[idx], 1'b0, 1'b0, acc);
            if (acc) begin
                accepted++;
                if (idx < 2) idx++;
            end
        end
        checkOutput("bp_accepted_while_stalled", accepted, 2);
        checkOutput("bp_in_ready_low", in_ready, 0);
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 16) begin
            applyStimulus(1'b1, bp_words[2], 1'b1, 1'b0, acc);
            tries++;
        end
        checkOutput("bp_third_accept", acc, 1);
        drain(4);

        $display("[TB] Random stream of 1024 words");
        for (int i = 0; i < 1024; i++) begin
            if (i == 600) midReset();
            w = randomWord();
            if ($urandom_range(0, 4) == 0) applyStimulus(1'b0, 16'($urandom), 1'b1, 1'b0, acc);
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 64) begin
                applyStimulus(1'b1, w,
                              !((cycle % 40) >= 10 && (cycle % 40) < 15) && ($urandom_range(0, 5) != 0),
                              1'b0, acc);
                tries++;
            end
            if (!acc) checkOutput("accept_timeout", acc, 1);
        end
        drain(6);

        $display("[TB] Saturating the uncorrectable counter");
        for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0, acc);
        drain(4);
        checkOutput("unc_saturated", uncorrectable_count, 16'hFFFF);

        $display("[TB] Clear coinciding with an increment");
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, acc);
        checkOutput("clear_pending_unc", out_uncorrectable, 1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, acc);
        checkOutput("clear_wins_unc", uncorrectable_count, 0);
        checkOutput("clear_wins_corr", corrected_count, 0);
        drain(3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
